wave_capture: RTL and testbench

- Upstream feeder of the waveform pause/freeze stage. Takes raw 12-bit microphone samples on a sample strobe and decimates them by block averaging.
- Scales each averaged sample to 10 bits and stores it in a display-width ring buffer. The display read port supplies `wave_sample[9:0]` to the downstream pause stage.
- Supports a frame-aligned freeze, so a captured screen is always one coherent sweep.

---
 rtl/wave_capture.sv | 140 ++++++++++++++
 tb/tb_wave_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Decimating waveform capture: block-averages mic samples into a display-width ring buffer
// with a registered read port and a frame-aligned freeze.
module wave_capture #(
  parameter int SAMPLE_W = 12,
  parameter int OUT_W    = 10,
  parameter int DECIM    = 4,
  parameter int DEPTH    = 640,
  parameter int ADDR_W   = 10
) (
  input  logic                CLOCK,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [OUT_W-1:0]    wave_sample,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                frame_done,
  output logic                frozen
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = SAMPLE_W + LOG2D;
  localparam int CNT_W = (LOG2D > 0) ? LOG2D : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHIFT = LOG2D + SAMPLE_W - OUT_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_CAPTURE = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_FROZEN  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_frame_done;
  logic              r_frozen;
  logic [OUT_W-1:0]  r_rd_data;
  logic [OUT_W-1:0]  r_mem [DEPTH];

  logic              w_tick_en;
  logic              w_last;
  logic              w_we;
  logic              w_at_end;
  logic              w_boundary;
  logic              w_rd_ok;
  logic [ACC_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_point;
  logic [ADDR_W-1:0] w_ptr_inc;

  // Ticks are dropped entirely while frozen, including on the release edge.
  assign w_tick_en  = sample_tick && (r_state != ST_FROZEN);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_we       = w_tick_en && w_last;
  assign w_at_end   = (r_wr_ptr == PTR_LAST);
  assign w_boundary = (r_wr_ptr == '0) && (r_cnt == '0) && !sample_tick;
  assign w_ptr_inc  = w_at_end ? '0 : r_wr_ptr + ADDR_W'(1);

  // Accumulator is wide enough for DECIM full-scale samples, so the sum never overflows.
  assign w_sum   = r_acc + ACC_W'(mic_in);
  assign w_point = OUT_W'(w_sum >> SHIFT);

  assign w_rd_ok = ({1'b0, rd_addr} < DEPTH_X);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CAPTURE: begin
        if (freeze) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!freeze)
          w_state_next = ST_CAPTURE;
        else if (w_we && w_at_end)
          w_state_next = ST_FROZEN;
        else if (w_boundary)
          w_state_next = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (!freeze) w_state_next = ST_CAPTURE;
      end
      default: w_state_next = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      r_state      <= ST_CAPTURE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_frame_done <= 1'b0;
      r_frozen     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_we && w_at_end;
      r_frozen     <= (r_state == ST_FROZEN);
      if (r_state == ST_FROZEN) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_wr_ptr <= '0;
      end else if (w_tick_en) begin
        if (w_last) begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_wr_ptr <= w_ptr_inc;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Buffer is deliberately unreset so it maps onto block RAM.
  always_ff @(posedge CLOCK) begin
    if (w_we) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_point;
  end

  // Read-first: a same-cycle write to rd_addr is not visible until the next read.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset)
      r_rd_data <= '0;
    else if (w_rd_ok)
      r_rd_data <= r_mem[rd_addr[IDX_W-1:0]];
    else
      r_rd_data <= '0;
  end

  assign wave_sample = r_rd_data;
  assign wr_ptr      = r_wr_ptr;
  assign frame_done  = r_frame_done;
  assign frozen      = r_frozen;

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: a behavioural model predicts buffer contents,
// expected read data is queued at issue and compared when the registered read appears.
module tb_wave_capture;
  localparam int SW = 12;
  localparam int OW = 10;
  localparam int DC = 4;
  localparam int DP = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          frz = 1'b0;
  logic [SW-1:0] mic = '0;
  logic [AW-1:0] rda = '0;
  logic [OW-1:0] ws;
  logic [AW-1:0] wp;
  logic          fd;
  logic          fzn;

  always #5 clk = ~clk;

  wave_capture #(.SAMPLE_W(SW), .OUT_W(OW), .DECIM(DC), .DEPTH(DP), .ADDR_W(AW)) dut (
    .CLOCK(clk), .reset(rst), .sample_tick(tick), .mic_in(mic), .freeze(frz),
    .rd_addr(rda), .wave_sample(ws), .wr_ptr(wp), .frame_done(fd), .frozen(fzn)
  );

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] sb[$];
  logic [OW-1:0] m_mem [DP];
  int m_ptr, m_acc, m_cnt;
  bit m_hold, m_drain;
  int fd_count = 0;
  int frz_count = 0;
  logic [OW-1:0] exp_v;

  always @(posedge clk) begin
    if (fd === 1'b1) fd_count <= fd_count + 1;
    if (fzn === 1'b1) frz_count <= frz_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic m_reset();
    m_ptr = 0; m_acc = 0; m_cnt = 0; m_hold = 0; m_drain = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_tick(input int v);
    tick = 1'b1;
    mic  = v[SW-1:0];
    @(posedge clk); #1;
    tick = 1'b0;
    if (!m_hold) begin
      m_acc += v;
      m_cnt++;
      if (m_cnt == DC) begin
        m_mem[m_ptr] = OW'((m_acc / DC) >> (SW - OW));
        if (m_drain && m_ptr == DP - 1) m_hold = 1;
        m_ptr = (m_ptr + 1) % DP;
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic rd_issue(input int addr);
    rda = AW'(addr);
    sb.push_back((addr < DP) ? m_mem[addr] : OW'(0));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++; if (ws !== '0)   begin failures++; $display("FAIL reset_wave_sample: got %0d expected 0", ws); end
    checks++; if (wp !== '0)   begin failures++; $display("FAIL reset_wr_ptr: got %0d expected 0", wp); end
    checks++; if (fd !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %0b expected 0", fd); end
    checks++; if (fzn !== 1'b0) begin failures++; $display("FAIL reset_frozen: got %0b expected 0", fzn); end
    rst = 1'b0;
    m_reset();
    idle(1);
    $display("test_reset done");
  endtask

  task automatic test_basic_write();
    do_tick(100); do_tick(200);
    checks++; if (wp !== AW'(0)) begin failures++; $display("FAIL basic_partial_ptr: got %0d expected 0", wp); end
    do_tick(300); do_tick(400);
    checks++; if (wp !== AW'(m_ptr)) begin failures++; $display("FAIL basic_ptr: got %0d expected %0d", wp, m_ptr); end
    rd_issue(0);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL basic_col0: got %0d expected %0d", ws, exp_v); end
    $display("test_basic_write col0=%0d", ws);
  endtask

  task automatic test_wrap();
    int f0;
    rst = 1'b1; idle(1); rst = 1'b0; m_reset();
    f0 = fd_count;
    repeat (32) do_tick(4095);
    idle(2);
    checks++; if (fd_count - f0 != 1) begin failures++; $display("FAIL wrap_one_pulse: got %0d expected 1", fd_count - f0); end
    checks++; if (wp !== AW'(0)) begin failures++; $display("FAIL wrap_ptr: got %0d expected 0", wp); end
    for (int c = 0; c < DP; c++) begin
      rd_issue(c);
      exp_v = sb.pop_front();
      checks++; if (ws !== exp_v) begin failures++; $display("FAIL wrap_col%0d: got %0d expected %0d", c, ws, exp_v); end
    end
    f0 = fd_count;
    repeat (64) do_tick(4095);
    idle(2);
    checks++; if (fd_count - f0 != 2) begin failures++; $display("FAIL wrap_two_pulses: got %0d expected 2", fd_count - f0); end
    $display("test_wrap done ptr=%0d", wp);
  endtask

  task automatic test_average();
    repeat (DP * DC) do_tick(int'($urandom_range(0, 4095)));
    for (int c = 0; c < DP; c++) begin
      rd_issue(c);
      exp_v = sb.pop_front();
      checks++; if (ws !== exp_v) begin failures++; $display("FAIL avg_col%0d: got %0d expected %0d", c, ws, exp_v); end
    end
    $display("test_average done");
  endtask

  task automatic test_freeze();
    int f0;
    repeat (3 * DC) do_tick(int'($urandom_range(0, 4095)));
    f0 = fd_count;
    frz = 1'b1; m_drain = 1;
    idle(1);
    repeat (5 * DC) do_tick(int'($urandom_range(0, 4095)));
    idle(2);
    checks++; if (fzn !== 1'b1) begin failures++; $display("FAIL freeze_frozen: got %0b expected 1", fzn); end
    checks++; if (wp !== AW'(0)) begin failures++; $display("FAIL freeze_ptr: got %0d expected 0", wp); end
    checks++; if (fd_count - f0 != 1) begin failures++; $display("FAIL freeze_pulse: got %0d expected 1", fd_count - f0); end
    repeat (2 * DC) do_tick(int'($urandom_range(0, 4095)));
    for (int c = 0; c < DP; c++) begin
      rd_issue(c);
      exp_v = sb.pop_front();
      checks++; if (ws !== exp_v) begin failures++; $display("FAIL frozen_col%0d: got %0d expected %0d", c, ws, exp_v); end
    end
    $display("test_freeze done frozen=%0b", fzn);
  endtask

  task automatic test_release();
    frz = 1'b0;
    do_tick(1234);
    m_hold = 0; m_drain = 0;
    idle(2);
    checks++; if (fzn !== 1'b0) begin failures++; $display("FAIL release_frozen: got %0b expected 0", fzn); end
    repeat (DC) do_tick(int'($urandom_range(0, 4095)));
    checks++; if (wp !== AW'(m_ptr)) begin failures++; $display("FAIL release_ptr: got %0d expected %0d", wp, m_ptr); end
    rd_issue(0);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL release_col0: got %0d expected %0d", ws, exp_v); end
    $display("test_release done ptr=%0d", wp);
  endtask

  task automatic test_cancel();
    int z0;
    z0 = frz_count;
    frz = 1'b1; m_drain = 1;
    idle(1);
    repeat (6) do_tick(int'($urandom_range(0, 4095)));
    frz = 1'b0; m_drain = 0;
    idle(1);
    repeat (30) do_tick(int'($urandom_range(0, 4095)));
    idle(2);
    checks++; if (frz_count - z0 != 0) begin failures++; $display("FAIL cancel_no_freeze: got %0d frozen cycles expected 0", frz_count - z0); end
    checks++; if (wp !== AW'(m_ptr)) begin failures++; $display("FAIL cancel_ptr: got %0d expected %0d", wp, m_ptr); end
    for (int c = 0; c < DP; c++) begin
      rd_issue(c);
      exp_v = sb.pop_front();
      checks++; if (ws !== exp_v) begin failures++; $display("FAIL cancel_col%0d: got %0d expected %0d", c, ws, exp_v); end
    end
    $display("test_cancel done ptr=%0d", wp);
  endtask

  task automatic test_read_edge();
    int col;
    rd_issue(DP);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL rd_oob8: got %0d expected %0d", ws, exp_v); end
    rd_issue(15);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL rd_oob15: got %0d expected %0d", ws, exp_v); end
    repeat (DC - 1) do_tick(int'($urandom_range(0, 4095)));
    col = m_ptr;
    rda = AW'(col);
    sb.push_back(m_mem[col]);
    do_tick(int'($urandom_range(0, 4095)));
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL rd_collision_old: got %0d expected %0d", ws, exp_v); end
    rd_issue(col);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL rd_after_write: got %0d expected %0d", ws, exp_v); end
    $display("test_read_edge done col=%0d", col);
  endtask

  task automatic test_async_reset();
    frz = 1'b1; m_drain = 1;
    idle(1);
    do_tick(int'($urandom_range(0, 4095)));
    do_tick(int'($urandom_range(0, 4095)));
    #2 rst = 1'b1;
    #1;
    checks++; if (wp !== AW'(0)) begin failures++; $display("FAIL arst_drain_ptr: got %0d expected 0", wp); end
    checks++; if (fzn !== 1'b0) begin failures++; $display("FAIL arst_drain_frozen: got %0b expected 0", fzn); end
    frz = 1'b0;
    #1 rst = 1'b0;
    m_reset();
    frz = 1'b1; m_drain = 1; m_hold = 1;
    idle(4);
    checks++; if (fzn !== 1'b1) begin failures++; $display("FAIL boundary_freeze: got %0b expected 1", fzn); end
    #2 rst = 1'b1;
    #1;
    checks++; if (fzn !== 1'b0) begin failures++; $display("FAIL arst_frozen: got %0b expected 0", fzn); end
    frz = 1'b0;
    #1 rst = 1'b0;
    m_reset();
    repeat (DC) do_tick(int'($urandom_range(0, 4095)));
    checks++; if (wp !== AW'(1)) begin failures++; $display("FAIL arst_ptr_after: got %0d expected 1", wp); end
    rd_issue(0);
    exp_v = sb.pop_front();
    checks++; if (ws !== exp_v) begin failures++; $display("FAIL arst_col0: got %0d expected %0d", ws, exp_v); end
    $display("test_async_reset done");
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic_write();
    test_wrap();
    test_average();
    test_freeze();
    test_release();
    test_cancel();
    test_read_edge();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
